// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE arbitrates, WAIT awaits the response)
//   arb_owner_e : which requester owns the single outstanding transaction
//   IF_BE_ALL   : all-ones byte-enable source for instruction fetches; users
//                 slice the low DW/8 bits
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } arb_owner_e;

  // Wide enough for any practical data width; fetches always read whole words.
  localparam logic [127:0] IF_BE_ALL = '1;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified memory port between the instruction-fetch (IF) and
// load/store (LS) requesters. Only one transaction is outstanding at a time.
// LS has fixed priority, but after STARVE_LIMIT consecutive LS grants taken
// while IF was waiting, IF is forced to win the next arbitration.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt                      fetch accepted (1-cycle pulse)
//   if_rvalid/if_rdata          fetch response (rdata is 0 when not valid)
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_be              load/store request (held until ls_gnt)
//   ls_gnt                      load/store accepted
//   ls_rvalid/ls_rdata          load data / store completion (rdata 0 when
//                               not valid)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be            request toward memory (all 0 with no winner)
//   mem_gnt                     memory accepted mem_req this cycle
//   mem_rvalid/mem_rdata        memory response for reads and writes
//   busy                        a transaction is outstanding
//   err                         sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,

  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,

  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,

  output logic            busy,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  arb_state_e    r_state, w_state_nxt;
  arb_owner_e    r_owner, w_owner_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;

  logic          w_if_win;
  logic          w_ls_win;

  // IF wins only when LS is absent or IF has been starved for the full limit.
  assign w_if_win = if_req && (!ls_req || (r_cnt == CNT_MAX));
  assign w_ls_win = ls_req && !w_if_win;

  // A response arriving while nothing is outstanding is a protocol error.
  assign w_err_nxt = r_err | ((r_state == ARB_IDLE) && mem_rvalid);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;

    if_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    if_rdata    = '0;
    ls_gnt      = 1'b0;
    ls_rvalid   = 1'b0;
    ls_rdata    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    busy        = 1'b0;

    // NOTE: the outputs are combinational on the request inputs, so they are
    // also qualified by rst_n to hold every output at 0 during reset.
    if (rst_n) begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_if_win) begin
            mem_req  = 1'b1;
            mem_addr = if_addr;
            mem_be   = IF_BE_ALL[BW-1:0];
            if_gnt   = mem_gnt;
          end else if (w_ls_win) begin
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = ls_be;
            ls_gnt    = mem_gnt;
          end

          if (if_gnt) begin
            w_state_nxt = ARB_WAIT;
            w_owner_nxt = OWN_IF;
            w_cnt_nxt   = '0;
          end else if (ls_gnt) begin
            w_state_nxt = ARB_WAIT;
            w_owner_nxt = OWN_LS;
            // Only LS grants taken while IF is actually waiting count
            // toward starvation.
            if (!if_req) begin
              w_cnt_nxt = '0;
            end else if (r_cnt != CNT_MAX) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end

        ARB_WAIT: begin
          busy = 1'b1;
          if (mem_rvalid) begin
            if (r_owner == OWN_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end else if (r_owner == OWN_LS) begin
              ls_rvalid = 1'b1;
              ls_rdata  = mem_rdata;
            end
            // No grant in the response cycle; arbitration resumes next cycle.
            w_state_nxt = ARB_IDLE;
            w_owner_nxt = OWN_NONE;
          end
        end

        default: begin
          w_state_nxt = ARB_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_NONE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign err = r_err;

  // ---------------------------------------------------------------------------
  // Architectural properties
  // ---------------------------------------------------------------------------
  a_gnt_needs_mem_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (if_gnt || ls_gnt) |-> mem_gnt);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_gnt && ls_gnt));

  a_one_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ARB_WAIT) |-> (!mem_req && !if_gnt && !ls_gnt));

  a_if_rvalid_owner: assert property (@(posedge clk) disable iff (!rst_n)
    if_rvalid |-> (r_owner == OWN_IF));

  a_ls_rvalid_owner: assert property (@(posedge clk) disable iff (!rst_n)
    ls_rvalid |-> (r_owner == OWN_LS));

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Requests sit in per-requester
// queues and are presented until granted; each grant pushes the expected
// response onto a scoreboard that is popped when a requester rvalid appears.
// A 1-cycle memory device answers every accepted mem_req.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [BW-1:0] ls_be;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } req_t;

  typedef struct packed {
    logic          is_ls;
    logic [DW-1:0] data;
  } rsp_t;

  req_t if_q[$];
  req_t ls_q[$];
  rsp_t sb_q[$];
  int   grant_cyc[$];
  int   rvalid_cyc[$];

  // Grant order as a bit string behind a leading 1 marker: 1 = LS, 0 = IF.
  logic [63:0] log_bits;

  logic [DW-1:0] mem [0:255];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic gnt_en, drop_resp, spur, resp_pend, exp_err;
  logic [DW-1:0] resp_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic req_t mk_if(input logic [AW-1:0] a);
    mk_if = '{we: 1'b0, addr: a, wdata: '0, be: 4'hF};
  endfunction

  function automatic req_t mk_ls(input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [BW-1:0] b);
    mk_ls = '{we: w, addr: a, wdata: d, be: b};
  endfunction

  task automatic drive_reqs();
    if_req   = (if_q.size() != 0);
    if_addr  = if_req ? if_q[0].addr : '0;
    ls_req   = (ls_q.size() != 0);
    ls_we    = ls_req ? ls_q[0].we    : 1'b0;
    ls_addr  = ls_req ? ls_q[0].addr  : '0;
    ls_wdata = ls_req ? ls_q[0].wdata : '0;
    ls_be    = ls_req ? ls_q[0].be    : '0;
  endtask

  task automatic observe();
    req_t r;
    rsp_t s;
    logic had_out;
    had_out = (sb_q.size() != 0);
    check("busy", 64'(busy), 64'(had_out));
    check("err", 64'(err), 64'(exp_err));
    if (!if_rvalid) check("if_rdata_zero", 64'(if_rdata), 64'(0));
    if (!ls_rvalid) check("ls_rdata_zero", 64'(ls_rdata), 64'(0));

    if (if_rvalid || ls_rvalid) begin
      rvalid_cyc.push_back(cyc);
      check("rvalid_onehot", 64'(if_rvalid & ls_rvalid), 64'(0));
      if (!had_out) begin
        check("rvalid_unexpected", 64'({if_rvalid, ls_rvalid}), 64'(0));
      end else begin
        s = sb_q.pop_front();
        check("rvalid_is_ls", 64'(ls_rvalid), 64'(s.is_ls));
        check("rdata", 64'(ls_rvalid ? ls_rdata : if_rdata), 64'(s.data));
      end
    end
    if (mem_rvalid && !had_out) exp_err = 1'b1;

    if (had_out) check("mem_req_in_wait", 64'(mem_req), 64'(0));

    if (if_gnt || ls_gnt) begin
      check("gnt_onehot", 64'(if_gnt & ls_gnt), 64'(0));
      check("gnt_with_mem_gnt", 64'(mem_gnt), 64'(1));
      check("gnt_with_mem_req", 64'(mem_req), 64'(1));
      if ((ls_gnt && ls_q.size() == 0) || (!ls_gnt && if_q.size() == 0)) begin
        check("gnt_no_request", 64'({if_gnt, ls_gnt}), 64'(0));
      end else begin
        if (ls_gnt) r = ls_q.pop_front();
        else        r = if_q.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(r.addr));
        check("mem_we", 64'(mem_we), 64'(r.we));
        check("mem_wdata", 64'(mem_wdata), 64'(r.wdata));
        check("mem_be", 64'(mem_be), 64'(r.be));
        if (grant_cyc.size() != 0)
          check("gnt_spacing", 64'((cyc - grant_cyc[grant_cyc.size()-1]) >= 2), 64'(1));
        grant_cyc.push_back(cyc);
        log_bits = {log_bits[62:0], ls_gnt};
        s.is_ls = ls_gnt;
        s.data  = r.we ? '0 : mem[r.addr[9:2]];
        sb_q.push_back(s);
      end
    end

    // Memory device: accept any presented request, answer one cycle later.
    if (mem_req && mem_gnt) begin
      resp_pend = 1'b1;
      resp_data = mem_we ? '0 : mem[mem_addr[9:2]];
      if (mem_we)
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mem_rvalid = (resp_pend && !drop_resp) || spur;
    mem_rdata  = (resp_pend && !drop_resp) ? resp_data : (spur ? 32'hBAD0BAD0 : '0);
    resp_pend  = 1'b0;
    spur       = 1'b0;
    mem_gnt    = gnt_en;
    drive_reqs();
    #1 observe();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((if_q.size() != 0 || ls_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(if_q.size() + ls_q.size() + sb_q.size()), 64'(0));
  endtask

  task automatic clear_logs();
    grant_cyc.delete();
    rvalid_cyc.delete();
    log_bits = 64'd1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
    check({tag, "_outputs_zero"}, 64'(|{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid,
          ls_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, err}), 64'(0));
    sb_q.delete();
    resp_pend = 1'b0;
    drop_resp = 1'b0;
    exp_err   = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int start;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i * 4);
    mem[0] = 32'h00500093;

    rst_n = 1'b0; gnt_en = 1'b1; drop_resp = 1'b0; spur = 1'b0;
    resp_pend = 1'b0; exp_err = 1'b0; resp_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    drive_reqs();
    clear_logs();
    repeat (2) @(negedge clk);
    do_reset("reset_initial");

    // Reset in the middle of an outstanding fetch; a request is held during reset.
    drop_resp = 1'b1;
    if_q.push_back(mk_if(32'h10));
    start = 0;
    while (grant_cyc.size() == 0 && start < 20) begin tick(); start++; end
    check("midwait_granted", 64'(grant_cyc.size()), 64'(1));
    tick();
    if_q.push_back(mk_if(32'h14));
    drive_reqs();
    do_reset("reset_midwait");
    clear_logs();
    drain("after_reset", 50);
    check("after_reset_order", log_bits, 64'b10);

    // IF only: back-to-back fetches, 1-cycle memory.
    clear_logs();
    if_q.push_back(mk_if(32'h0));
    if_q.push_back(mk_if(32'h4));
    drain("if_only", 50);
    check("if_only_order", log_bits, 64'b100);
    check("if_only_rvalid_lat", 64'(rvalid_cyc[0] - grant_cyc[0]), 64'(1));
    check("if_only_spacing", 64'(grant_cyc[1] - grant_cyc[0]), 64'(2));

    // Simultaneous requests with the counter clear: LS first.
    clear_logs();
    if_q.push_back(mk_if(32'h4));
    ls_q.push_back(mk_ls(1'b0, 32'h100, '0, 4'hF));
    drain("simul", 50);
    check("simul_order", log_bits, 64'b110);

    // Starvation: LS keeps requesting while IF waits.
    clear_logs();
    if_q.push_back(mk_if(32'h8));
    if_q.push_back(mk_if(32'hC));
    for (int i = 0; i < 6; i++) ls_q.push_back(mk_ls(1'b0, 32'h180 + 32'(i * 4), '0, 4'hF));
    drain("starve", 100);
    check("starve_order", log_bits, 64'b1_1111_0110);

    // Partial store, then read back the merged word.
    clear_logs();
    ls_q.push_back(mk_ls(1'b1, 32'h200, 32'hDEADBEEF, 4'b0011));
    drain("store", 50);
    check("store_merge", 64'(mem[32'h200 >> 2]), 64'(32'hC0DEBEEF));
    ls_q.push_back(mk_ls(1'b0, 32'h200, '0, 4'hF));
    drain("store_readback", 50);
    check("store_order", log_bits, 64'b111);

    // Memory stalls the grant: no requester grant, request stays presented.
    clear_logs();
    gnt_en = 1'b0;
    ls_q.push_back(mk_ls(1'b0, 32'h104, '0, 4'hF));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_mem_req", 64'(mem_req), 64'(1));
      check("stall_mem_addr", 64'(mem_addr), 64'(32'h104));
    end
    check("stall_no_gnt", 64'(grant_cyc.size()), 64'(0));
    gnt_en = 1'b1;
    drain("stall", 50);

    // Spurious response in IDLE sets the sticky error.
    spur = 1'b1;
    tick();
    tick();
    check("spur_err_set", 64'(err), 64'(1));
    if_q.push_back(mk_if(32'h8));
    drain("spur_after", 50);
    check("spur_err_sticky", 64'(err), 64'(1));
    do_reset("reset_clears_err");
    tick();
    check("err_after_reset", 64'(err), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter
